// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - WIDTH x DEPTH register pipeline with stall, clear, valid tracking and selectable tap
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              SW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [SW-1:0]    fill
);

  logic [WIDTH-1:0] r_s [DEPTH];
  logic [DEPTH-1:0] r_v;

  int               w_k;
  logic [WIDTH-1:0] w_q;
  logic             w_qv;
  logic [SW-1:0]    w_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_s[i] <= RESET_VAL;
      end
      r_v <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_s[i] <= RESET_VAL;
      end
      r_v <= '0;
    end else if (en) begin
      r_s[0] <= d;
      r_v[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_s[i] <= r_s[i-1];
        r_v[i] <= r_v[i-1];
      end
    end
  end

  // Out-of-range selects clamp to the nearest legal tap.
  always_comb begin
    w_k = 32'(sel) - 1;
    if (w_k < 0) w_k = 0;
    if (w_k > DEPTH - 1) w_k = DEPTH - 1;
  end

  always_comb begin
    w_q  = r_s[0];
    w_qv = r_v[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (w_k == i) begin
        w_q  = r_s[i];
        w_qv = r_v[i];
      end
    end
  end

  always_comb begin
    w_fill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fill = w_fill + SW'(r_v[i]);
    end
  end

  assign q       = w_q;
  assign q_valid = w_qv;
  assign fill    = w_fill;

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5)
module tb_dff_pipe;

  localparam int              WIDTH = 8;
  localparam int              DEPTH = 4;
  localparam logic [WIDTH-1:0] RV   = 8'hA5;
  localparam int              SW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [SW-1:0]    fill;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       dv;
    logic [2:0] sel;
    logic [7:0] eq;
    logic       eqv;
    logic [2:0] efill;
  } vec_t;

  vec_t vtab[$];
  int   sb[$];

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .d       (d),
    .d_valid (d_valid),
    .sel     (sel),
    .q       (q),
    .q_valid (q_valid),
    .fill    (fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic e, input logic c, input logic [7:0] dd, input logic dv,
                      input logic [2:0] s, input logic [7:0] eq, input logic eqv,
                      input logic [2:0] ef);
    vec_t v;
    v.en = e; v.clr = c; v.d = dd; v.dv = dv; v.sel = s;
    v.eq = eq; v.eqv = eqv; v.efill = ef;
    vtab.push_back(v);
  endtask

  initial begin
    int keff;
    logic [2:0] sweep [5];

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = '0; d_valid = 1'b0; sel = 3'd1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_q", int'(q), int'(RV));
    check("reset_qv", int'(q_valid), 0);
    check("reset_fill", int'(fill), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency sweep, including clamped selects 0 and 7.
    sweep[0] = 3'd3; sweep[1] = 3'd1; sweep[2] = 3'd4; sweep[3] = 3'd0; sweep[4] = 3'd7;
    for (int si = 0; si < 5; si++) begin
      sel = sweep[si];
      keff = (sweep[si] == 0) ? 1 : ((sweep[si] > DEPTH) ? DEPTH : int'(sweep[si]));
      clr = 1'b1; en = 1'b1; d_valid = 1'b0;
      step();
      clr = 1'b0;
      sb.delete();
      for (int n = 1; n <= 8; n++) begin
        d = 8'(16 * si + n);
        d_valid = 1'b1;
        step();
        sb.push_back(16 * si + n);
        if (sb.size() == keff) begin
          check($sformatf("lat_sel%0d_q", sweep[si]), int'(q), sb.pop_front());
          check($sformatf("lat_sel%0d_qv", sweep[si]), int'(q_valid), 1);
        end
      end
    end

    // en, clr, d, dv, sel -> q, q_valid, fill after the edge
    addv(1, 1, 8'd0,  0, 3, RV,    0, 0);
    addv(1, 0, 8'd10, 1, 3, RV,    0, 1);
    addv(1, 0, 8'd11, 1, 3, RV,    0, 2);
    addv(1, 0, 8'd12, 1, 3, 8'd10, 1, 3);
    addv(0, 0, 8'd99, 1, 3, 8'd10, 1, 3);
    addv(0, 0, 8'd99, 1, 3, 8'd10, 1, 3);
    addv(1, 0, 8'd13, 1, 3, 8'd11, 1, 4);
    addv(1, 0, 8'd14, 1, 3, 8'd12, 1, 4);
    addv(1, 0, 8'd15, 1, 3, 8'd13, 1, 4);
    addv(0, 1, 8'd0,  0, 4, RV,    0, 0);
    addv(1, 0, 8'd1,  1, 4, RV,    0, 1);
    addv(1, 0, 8'd2,  0, 4, RV,    0, 1);
    addv(1, 0, 8'd3,  1, 4, RV,    0, 2);
    addv(1, 0, 8'd4,  1, 4, 8'd1,  1, 3);
    addv(1, 0, 8'd5,  0, 4, 8'd2,  0, 2);
    addv(1, 0, 8'd6,  0, 4, 8'd3,  1, 2);
    addv(1, 0, 8'd7,  0, 4, 8'd4,  1, 1);
    addv(1, 0, 8'd8,  1, 4, 8'd5,  0, 1);
    addv(1, 0, 8'd9,  1, 4, 8'd6,  0, 2);
    addv(1, 0, 8'd10, 1, 4, 8'd7,  0, 3);
    addv(1, 0, 8'd11, 1, 4, 8'd8,  1, 4);
    addv(1, 1, 8'd7,  1, 4, RV,    0, 0);
    addv(1, 0, 8'd7,  1, 1, 8'd7,  1, 1);
    addv(0, 0, 8'd0,  0, 2, RV,    0, 1);
    addv(0, 0, 8'd0,  0, 0, 8'd7,  1, 1);
    addv(0, 0, 8'd0,  0, 7, RV,    0, 1);

    for (int i = 0; i < vtab.size(); i++) begin
      en = vtab[i].en; clr = vtab[i].clr; d = vtab[i].d;
      d_valid = vtab[i].dv; sel = vtab[i].sel;
      step();
      check($sformatf("vec%0d_q", i), int'(q), int'(vtab[i].eq));
      check($sformatf("vec%0d_qv", i), int'(q_valid), int'(vtab[i].eqv));
      check($sformatf("vec%0d_fill", i), int'(fill), int'(vtab[i].efill));
      if (vtab[i].efill == 0) begin
        for (int s = 0; s < 8; s++) begin
          sel = 3'(s);
          #1;
          check($sformatf("vec%0d_empty_sel%0d_q", i, s), int'(q), int'(RV));
          check($sformatf("vec%0d_empty_sel%0d_qv", i, s), int'(q_valid), 0);
        end
      end
    end

    // Asynchronous reset in the middle of a stream.
    clr = 1'b1; en = 1'b1; step();
    clr = 1'b0; sel = 3'd2;
    for (int n = 0; n < 3; n++) begin
      d = 8'(8'h30 + n); d_valid = 1'b1; step();
    end
    check("mid_fill_before", int'(fill), 3);
    check("mid_q_before", int'(q), 8'h31);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", int'(q), int'(RV));
    check("mid_rst_qv", int'(q_valid), 0);
    check("mid_rst_fill", int'(fill), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sel = 3'd1; d = 8'h42; d_valid = 1'b1; en = 1'b1;
    step();
    check("resume_q", int'(q), 8'h42);
    check("resume_qv", int'(q_valid), 1);
    check("resume_fill", int'(fill), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
